// File: rtl/countdown_timer.sv
// countdown_timer: mm:ss BCD countdown with key-driven preset, pause/resume and sticky alarm.
// Keys are synchronized and edge-detected; outputs share the stopwatch digit format.
module countdown_timer #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic       clk_50Mhz,
    input  logic       reset,
    input  logic       key_mode,
    input  logic       key_adj,
    input  logic       key_run,
    output logic [3:0] dvseconds_count,
    output logic [3:0] chucseconds_count,
    output logic [3:0] dvminutes_count,
    output logic [3:0] chucminutes_count,
    output logic [1:0] edit_field,
    output logic       running,
    output logic       alarm
);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    typedef enum logic [2:0] {IDLE, SET_MIN, SET_SEC, RUN, PAUSE, DONE} state_t;

    state_t        state_q, state_d;
    logic [2:0]    sync1, sync2, prev, ev;
    logic [15:0]   time_q, time_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          run_ev, mode_ev, adj_ev, zero, tick;

    function automatic logic [7:0] inc60(input logic [7:0] f);
        return (f[3:0] == 4'd9) ? ((f[7:4] == 4'd5) ? 8'h00 : {f[7:4] + 4'd1, 4'd0})
                                : {f[7:4], f[3:0] + 4'd1};
    endfunction

    function automatic logic [15:0] dec_time(input logic [15:0] t);
        if (t[3:0] != 4'd0)
            return {t[15:4], t[3:0] - 4'd1};
        if (t[7:4] != 4'd0)
            return {t[15:8], t[7:4] - 4'd1, 4'd9};
        if (t[11:8] != 4'd0)
            return {t[15:12], t[11:8] - 4'd1, 4'd5, 4'd9};
        return {t[15:12] - 4'd1, 4'd9, 4'd5, 4'd9};
    endfunction

    // Key order in the vectors is {run, mode, adj}; events are registered one-cycle pulses
    always_ff @(posedge clk_50Mhz) begin
        if (!reset) begin
            sync1 <= '1;
            sync2 <= '1;
            prev  <= '1;
            ev    <= '0;
        end else begin
            sync1 <= {key_run, key_mode, key_adj};
            sync2 <= sync1;
            prev  <= sync2;
            ev    <= prev & ~sync2;
        end
    end

    assign run_ev  = ev[2];
    assign mode_ev = ev[1] & ~ev[2];
    assign adj_ev  = ev[0] & ~ev[2] & ~ev[1];
    assign zero    = time_q == '0;
    assign tick    = presc_q == LAST;

    always_comb begin
        state_d = state_q;
        time_d  = time_q;
        presc_d = presc_q;
        case (state_q)
            IDLE: begin
                if (run_ev) begin
                    if (!zero) begin
                        state_d = RUN;
                        presc_d = '0;
                    end
                end else if (mode_ev)
                    state_d = SET_MIN;
            end
            SET_MIN, SET_SEC: begin
                if (run_ev) begin
                    if (!zero) begin
                        state_d = RUN;
                        presc_d = '0;
                    end
                end else if (mode_ev)
                    state_d = (state_q == SET_MIN) ? SET_SEC : IDLE;
                else if (adj_ev)
                    time_d = (state_q == SET_MIN) ? {inc60(time_q[15:8]), time_q[7:0]}
                                                  : {time_q[15:8], inc60(time_q[7:0])};
            end
            RUN: begin
                if (run_ev)
                    state_d = PAUSE;
                else begin
                    presc_d = tick ? '0 : presc_q + 1'b1;
                    if (tick) begin
                        time_d  = dec_time(time_q);
                        state_d = (dec_time(time_q) == '0) ? DONE : RUN;
                    end
                end
            end
            PAUSE: begin
                if (run_ev)
                    state_d = RUN;
                else if (mode_ev)
                    state_d = SET_MIN;
            end
            DONE: state_d = (ev != '0) ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_50Mhz) begin
        if (!reset) begin
            state_q    <= IDLE;
            time_q     <= '0;
            presc_q    <= '0;
            edit_field <= 2'b00;
            running    <= 1'b0;
            alarm      <= 1'b0;
        end else begin
            state_q    <= state_d;
            time_q     <= time_d;
            presc_q    <= presc_d;
            edit_field <= (state_d == SET_MIN) ? 2'b01 : (state_d == SET_SEC) ? 2'b10 : 2'b00;
            running    <= state_d == RUN;
            alarm      <= state_d == DONE;
        end
    end

    assign {chucminutes_count, dvminutes_count, chucseconds_count, dvseconds_count} = time_q;
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: table vectors, hand-written timing sequences and a random run
// against a seconds-based reference model of the countdown timer.
module tb_countdown_timer;
    localparam int TD = 4;
    localparam int M_IDLE = 0, M_SMIN = 1, M_SSEC = 2, M_RUN = 3, M_PAUSE = 4, M_DONE = 5;

    logic clk_50Mhz = 1'b0;
    logic reset = 1'b0;
    logic key_mode = 1'b1, key_adj = 1'b1, key_run = 1'b1;
    logic [3:0] dvseconds_count, chucseconds_count, dvminutes_count, chucminutes_count;
    logic [1:0] edit_field;
    logic running, alarm;
    logic [19:0] obs;

    int checks = 0;
    int errors = 0;

    int m_st, m_secs, m_cnt;
    logic [2:0] h [4];

    typedef struct {
        logic [2:0]  keys;
        logic [15:0] dig;
        logic [1:0]  ed;
        logic        run;
        logic        alm;
    } vec_t;
    vec_t tbl [9];

    countdown_timer #(.TICK_DIV(TD)) dut (
        .clk_50Mhz(clk_50Mhz),
        .reset(reset),
        .key_mode(key_mode),
        .key_adj(key_adj),
        .key_run(key_run),
        .dvseconds_count(dvseconds_count),
        .chucseconds_count(chucseconds_count),
        .dvminutes_count(dvminutes_count),
        .chucminutes_count(chucminutes_count),
        .edit_field(edit_field),
        .running(running),
        .alarm(alarm)
    );

    always #5 clk_50Mhz = ~clk_50Mhz;

    assign obs = {chucminutes_count, dvminutes_count, chucseconds_count, dvseconds_count,
                  edit_field, running, alarm};

    function automatic logic [19:0] ex(input logic [15:0] d, input logic [1:0] e,
                                       input logic r, input logic a);
        return {d, e, r, a};
    endfunction

    function automatic logic [19:0] mexp();
        int mins, s;
        mins = m_secs / 60;
        s = m_secs % 60;
        return {4'(mins / 10), 4'(mins % 10), 4'(s / 10), 4'(s % 10),
                (m_st == M_SMIN) ? 2'b01 : (m_st == M_SSEC) ? 2'b10 : 2'b00,
                m_st == M_RUN, m_st == M_DONE};
    endfunction

    // Reference: time kept as total seconds; a key event is a pin low three edges back after high four back
    task automatic model_edge(input logic [2:0] p, input logic r);
        logic [2:0] ev;
        logic run, mode, adj;
        int mins, s;
        if (!r) begin
            for (int i = 0; i < 4; i++) h[i] = 3'b111;
            m_st = M_IDLE;
            m_secs = 0;
            m_cnt = 0;
        end else begin
            ev = ~h[2] & h[3];
            h[3] = h[2];
            h[2] = h[1];
            h[1] = h[0];
            h[0] = p;
            run = ev[2];
            mode = ev[1] && !ev[2];
            adj = ev[0] && ev[2:1] == 2'b00;
            mins = m_secs / 60;
            s = m_secs % 60;
            case (m_st)
                M_IDLE, M_SMIN, M_SSEC: begin
                    if (run) begin
                        if (m_secs != 0) begin
                            m_st = M_RUN;
                            m_cnt = 0;
                        end
                    end else if (mode)
                        m_st = (m_st == M_SSEC) ? M_IDLE : m_st + 1;
                    else if (adj && m_st == M_SMIN)
                        m_secs = ((mins + 1) % 60) * 60 + s;
                    else if (adj && m_st == M_SSEC)
                        m_secs = mins * 60 + (s + 1) % 60;
                end
                M_RUN: begin
                    if (run)
                        m_st = M_PAUSE;
                    else begin
                        m_cnt++;
                        if (m_cnt == TD) begin
                            m_cnt = 0;
                            m_secs--;
                            if (m_secs == 0) m_st = M_DONE;
                        end
                    end
                end
                M_PAUSE: begin
                    if (run) m_st = M_RUN;
                    else if (mode) m_st = M_SMIN;
                end
                default: if (ev != 3'b000) m_st = M_IDLE;
            endcase
        end
    endtask

    task automatic cyc(input logic [2:0] pins, input logic r);
        @(negedge clk_50Mhz);
        {key_run, key_mode, key_adj} = pins;
        reset = r;
        @(posedge clk_50Mhz);
        model_edge(pins, r);
        #1;
    endtask

    task automatic press(input logic [2:0] mask, input int hold);
        for (int i = 0; i < hold; i++) cyc(~mask, 1'b1);
        repeat (4) cyc(3'b111, 1'b1);
    endtask

    task automatic check(input string nm, input logic [19:0] act, input logic [19:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    initial begin
        logic [2:0] p;
        logic r;
        tbl[0] = '{3'b100, 16'h0000, 2'b00, 1'b0, 1'b0};
        tbl[1] = '{3'b010, 16'h0000, 2'b01, 1'b0, 1'b0};
        tbl[2] = '{3'b001, 16'h0100, 2'b01, 1'b0, 1'b0};
        tbl[3] = '{3'b001, 16'h0200, 2'b01, 1'b0, 1'b0};
        tbl[4] = '{3'b001, 16'h0300, 2'b01, 1'b0, 1'b0};
        tbl[5] = '{3'b010, 16'h0300, 2'b10, 1'b0, 1'b0};
        tbl[6] = '{3'b001, 16'h0301, 2'b10, 1'b0, 1'b0};
        tbl[7] = '{3'b001, 16'h0302, 2'b10, 1'b0, 1'b0};
        tbl[8] = '{3'b010, 16'h0302, 2'b00, 1'b0, 1'b0};

        cyc(3'b111, 1'b0);
        cyc(3'b111, 1'b0);
        check("reset", obs, '0);
        for (int i = 0; i < 9; i++) begin
            press(tbl[i].keys, 1);
            check($sformatf("vec%0d", i), obs, ex(tbl[i].dig, tbl[i].ed, tbl[i].run, tbl[i].alm));
        end

        // 01:00 countdown to expiry
        cyc(3'b111, 1'b0);
        press(3'b010, 1); press(3'b001, 1); press(3'b010, 1); press(3'b010, 1);
        cyc(3'b011, 1'b1);
        repeat (3) cyc(3'b111, 1'b1);
        check("run_entry", obs, ex(16'h0100, 2'b00, 1'b1, 1'b0));
        repeat (3) cyc(3'b111, 1'b1);
        check("pre_tick", obs, ex(16'h0100, 2'b00, 1'b1, 1'b0));
        cyc(3'b111, 1'b1);
        check("first_dec", obs, ex(16'h0059, 2'b00, 1'b1, 1'b0));
        repeat (235) cyc(3'b111, 1'b1);
        check("one_left", obs, ex(16'h0001, 2'b00, 1'b1, 1'b0));
        cyc(3'b111, 1'b1);
        check("expire", obs, ex(16'h0000, 2'b00, 1'b0, 1'b1));
        repeat (5) cyc(3'b111, 1'b1);
        check("alarm_sticky", obs, ex(16'h0000, 2'b00, 1'b0, 1'b1));
        press(3'b001, 1);
        check("alarm_clear", obs, '0);

        // pause on the exact tick cycle, then resume from the held prescaler
        cyc(3'b111, 1'b0);
        press(3'b010, 1); press(3'b010, 1);
        repeat (10) press(3'b001, 1);
        press(3'b010, 1);
        check("preset10", obs, ex(16'h0010, 2'b00, 1'b0, 1'b0));
        cyc(3'b011, 1'b1);
        repeat (3) cyc(3'b111, 1'b1);
        cyc(3'b011, 1'b1);
        repeat (3) cyc(3'b111, 1'b1);
        check("pause_on_tick", obs, ex(16'h0010, 2'b00, 1'b0, 1'b0));
        repeat (6) cyc(3'b111, 1'b1);
        check("pause_hold", obs, ex(16'h0010, 2'b00, 1'b0, 1'b0));
        cyc(3'b011, 1'b1);
        repeat (3) cyc(3'b111, 1'b1);
        check("resume", obs, ex(16'h0010, 2'b00, 1'b1, 1'b0));
        cyc(3'b111, 1'b1);
        check("resume_dec", obs, ex(16'h0009, 2'b00, 1'b1, 1'b0));

        // field wrap at 59 and simultaneous keys
        cyc(3'b111, 1'b0);
        press(3'b010, 1); press(3'b010, 1);
        repeat (59) press(3'b001, 1);
        check("sec59", obs, ex(16'h0059, 2'b10, 1'b0, 1'b0));
        press(3'b001, 1);
        check("sec_wrap", obs, ex(16'h0000, 2'b10, 1'b0, 1'b0));
        press(3'b010, 1); press(3'b010, 1);
        repeat (59) press(3'b001, 1);
        check("min59", obs, ex(16'h5900, 2'b01, 1'b0, 1'b0));
        press(3'b001, 1);
        check("min_wrap", obs, ex(16'h0000, 2'b01, 1'b0, 1'b0));
        press(3'b001, 1);
        press(3'b111, 1);
        check("simul_keys", obs, ex(16'h0100, 2'b00, 1'b1, 1'b0));

        // reset mid-run, then a long key hold
        cyc(3'b111, 1'b0);
        press(3'b010, 1); press(3'b010, 1);
        repeat (37) press(3'b001, 1);
        press(3'b010, 1);
        press(3'b100, 1);
        check("run37", obs, ex(16'h0037, 2'b00, 1'b1, 1'b0));
        cyc(3'b111, 1'b0);
        check("mid_reset", obs, '0);
        press(3'b010, 1);
        press(3'b001, 20);
        check("hold_adj", obs, ex(16'h0100, 2'b01, 1'b0, 1'b0));

        // random key activity against the reference model
        p = 3'b111;
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < 3; b++)
                if ($urandom_range(0, 9) == 0) p[b] = ~p[b];
            r = ($urandom_range(0, 149) != 0);
            cyc(p, r);
            check("model", obs, mexp());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/countdown_timer.md
# countdown_timer

Down-counting companion to the stopwatch: a mm:ss countdown timer presetting, decrementing and expiring on the same four BCD digit outputs the stopwatch drives, so the existing seven-segment path displays either block unchanged. It runs on the board 50 MHz clock, derives its own 1 s tick, and is controlled by three active-low push keys: mode, adjust and run/pause. On reaching 00:00 it raises a sticky alarm.

## Interface
- TICK_DIV, 50_000_000: clk_50Mhz cycles per countdown second. Range 2..2^26.
- clk_50Mhz  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low; sampled on rising clk_50Mhz.
- key_mode  in  1  active-low push key: field select / edit exit. Asynchronous, externally debounced.
- key_adj  in  1  active-low push key: increment the selected field.
- key_run  in  1  active-low push key: start/pause toggle.
- dvseconds_count  out  4  seconds units, BCD 0..9.
- chucseconds_count  out  4  seconds tens, BCD 0..5.
- dvminutes_count  out  4  minutes units, BCD 0..9.
- chucminutes_count  out  4  minutes tens, BCD 0..5.
- edit_field  out  2  00 none, 01 minutes, 10 seconds; for display blink.
- running  out  1  high in RUN only.
- alarm  out  1  high in DONE only.

## Operation
- Reset (reset=0 at an edge): all digits 0, edit_field=00, running=0, alarm=0, state IDLE, prescaler 0, sync flops 1.
- Key front end per key: 2-flop synchronizer, then a previous-value register. Press event = previous 1 and synchronized 0, one cycle wide. Holding a key produces exactly one event.
- Simultaneous events: priority run > mode > adj; lower-priority events in the same cycle are dropped.
- "Zero" means all four digits equal 0.
- IDLE: mode -> SET_MIN. Run -> RUN if not zero, else ignored. Adj ignored.
- SET_MIN (edit_field=01): adj increments minutes 00..59, 59 -> 00; seconds untouched. Mode -> SET_SEC. Run -> RUN if not zero.
- SET_SEC (edit_field=10): adj increments seconds 00..59, 59 -> 00. Mode -> IDLE. Run -> RUN if not zero.
- RUN: prescaler counts 0..TICK_DIV-1 and wraps. Tick = prescaler at TICK_DIV-1. On a tick, mm:ss decrements by one second with BCD borrow: su 0 -> 9 borrowing from st; st 0 -> 5 borrowing from mu; mu 0 -> 9 borrowing from mt. Run event -> PAUSE. Mode and adj ignored.
- A tick that produces 00:00 moves the block to DONE on the same edge.
- PAUSE: digits and prescaler held. Run -> RUN, and the prescaler resumes from its held value. Mode -> SET_MIN with digits kept.
- DONE: digits hold 00:00 and alarm=1. Any key event -> IDLE, which clears alarm.
- Digits are never outside BCD range. Mid-operation reset overrides all activity.

## Timing
- A key pin low at rising edge N produces the press event during cycle N+2. The state or digit change is visible after edge N+3.
- Entering RUN from IDLE, SET_MIN or SET_SEC clears the prescaler. The first decrement is visible exactly TICK_DIV cycles after the edge that entered RUN.
- Run event in the same cycle as a tick: go to PAUSE and do not decrement.
- Outputs are registered; no combinational path from keys to outputs.
- running, alarm and edit_field change on the same edge as the state.

## Test plan
- TICK_DIV=4, reset low for 2 cycles -> all digits 0, edit_field 00, running 0, alarm 0. Then run press -> stays IDLE, running 0.
- Mode press, 3 adj presses, mode press, 2 adj presses, mode press -> digits read 03:02 in IDLE. edit_field sequence 01, 10, 00.
- Preset 01:00, run press -> running 1. After 4 cycles digits read 00:59; after 240 cycles total 00:00, alarm 1, running 0. Any key press -> alarm 0, IDLE.
- Preset 00:10, run; press run on the exact tick cycle -> PAUSE with 00:10 held. Resume -> next decrement to 00:09 after the remaining prescaler count, not a full 4 cycles.
- In SET_SEC at 59, adj -> 00. In SET_MIN at 59, adj -> 00. Run, mode and adj falling in the same cycle -> only the run action occurs.
- Reset asserted mid-RUN at 00:37 -> next edge: digits 0, IDLE. Holding key_adj low for 20 cycles in SET_MIN -> exactly one increment.
